detector_stream_ctrl: RTL
=========================

// Module: detector_stream_ctrl
// PURPOSE
//  Sequencer in front of the detector top (det55 / det59 / packet begin-end detector).
//  Accepts parallel words over valid/ready and serialises each word MSB-first onto the detectors' shared serial input.
//  Counts detector events over each word's window and returns a per-word result record over valid/ready.
//  Sits between the host-side word source and the detector top; the detectors themselves are unchanged.
// PARAMETERS
//  WORD_W  16  bits per input word, >=2
//  CNT_W   8   width of each per-word event counter; counters saturate at all-ones
//  DRAIN   1   extra cycles after the last bit during which detector outputs are still sampled (detector latency)
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        asynchronous, active-low reset
//  in_data      in   WORD_W   word to serialise
//  in_valid     in   1        in_data valid
//  in_ready     out  1        word accepted when in_valid & in_ready
//  ser_bit      out  1        serial bit to the detector dataIn
//  ser_en       out  1        1 while ser_bit carries a word bit
//  det55        in   1        detect55 pulse from detector top
//  det59        in   1        detect59 pulse from detector top
//  beg_p        in   1        packet-begin pulse
//  end_p        in   1        packet-end pulse
//  res_valid    out  1        result record valid
//  res_ready    in   1        result consumed when res_valid & res_ready
//  res_cnt55    out  CNT_W    det55 pulses in window
//  res_cnt59    out  CNT_W    det59 pulses in window
//  res_pkts     out  CNT_W    completed packets (end_p while in_packet) in window
//  res_err      out  1        end_p seen with in_packet=0, or any counter saturated, in window
//  in_packet    out  1        packet-open flag, persists across words
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; in_ready=1; ser_bit=0; ser_en=0; res_valid=0; all res_* =0; in_packet=0.
//  FSM IDLE -> SHIFT -> DRAIN -> REPORT -> IDLE.
//   IDLE:   in_ready=1. On accept: load shift reg, bit_cnt=WORD_W-1, clear window counters/err -> SHIFT.
//   SHIFT:  ser_en=1, ser_bit=shreg[WORD_W-1]; shift left each cycle; exactly WORD_W cycles; after the last bit -> DRAIN
//           (or -> REPORT directly if DRAIN=0).
//   DRAIN:  ser_en=0, ser_bit=0; DRAIN cycles; detector inputs are still counted.
//   REPORT: res_valid=1, fields stable until handshake; detector inputs ignored for counting; hold until res_ready -> IDLE.
//  Counting window: from the first SHIFT cycle through the last DRAIN cycle; in_ready=0 throughout SHIFT/DRAIN/REPORT.
//  Latency: accept at cycle T -> first bit at T+1 -> res_valid at T+1+WORD_W+DRAIN.
//  Throughput: one word per WORD_W+DRAIN+2 cycles with res_ready tied high.
//  Counters: +1 per cycle with the input high (inputs are 1-cycle pulses); at all-ones hold and set err.
//  Packet tracking (every cycle, including outside the window):
//   - end_p is processed before beg_p.
//   - end_p & in_packet: pkts++ (window only), in_packet<=0.
//   - end_p & !in_packet: err=1 (window only).
//   - beg_p: in_packet<=1. beg_p with in_packet=1 re-opens the packet; not an error.
//   - beg_p & end_p in the same cycle with in_packet=1: one packet counted, in_packet stays 1.
//  All outputs are registered; no combinational path from in_valid or res_ready to any output.
//  Reset asserted mid-word: the partial word is discarded and no result is emitted.
// STRUCTURE
//  Shared package det_pkg: state encoding localparams (IDLE=0, SHIFT=1, DRAIN=2, REPORT=3), default WORD_W/CNT_W.
//  Sub-module sat_counter (CNT_W, clr, inc -> cnt, sat): instantiated x3 (cnt55, cnt59, pkts); err ORs the sat flags.
//  Serialiser and FSM are kept in this module.
// TESTING  (detector inputs driven by bench stubs; WORD_W=16, CNT_W=8, DRAIN=1)
//  1. in_data=16'hA5C3 accepted -> ser_bit over 16 cycles = 1010010111000011, ser_en high exactly 16 cycles, res_valid at T+18.
//  2. det55 pulses 3x, det59 1x during the window -> res_cnt55=3, res_cnt59=1, res_err=0; a pulse during REPORT does not count.
//  3. beg_p@bit2, end_p@bit9, end_p@bit12 -> res_pkts=1, res_err=1, in_packet=0;
//     beg_p@bit14 of word n, end_p@bit3 of word n+1 -> word n+1 res_pkts=1.
//  4. det55 high for all 16+1 window cycles with CNT_W=4 -> res_cnt55=15, res_err=1.
//  5. res_ready held low 10 cycles -> res_* stable, in_ready=0, a second in_valid is not accepted; accepted the cycle after the handshake.
//  6. reset pulled low at bit 7 -> ser_en=0, res_valid=0, in_packet=0 immediately; next word completes normally.

Source files
------------

// File: rtl/detector_stream_ctrl_pkg.sv
// Shared definitions for the detector stream sequencer: state encoding and
// default geometry.
package det_pkg;

  localparam int DEF_WORD_W = 16;
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_DRAIN  = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

endpackage

// File: rtl/detector_stream_ctrl_if.sv
// Word input, serial output, detector pulses and result record of the
// detector stream sequencer, bundled as one interface.
interface detector_stream_ctrl_if
  import det_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int CNT_W  = DEF_CNT_W
);

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              ser_bit;
  logic              ser_en;
  logic              det55;
  logic              det59;
  logic              beg_p;
  logic              end_p;
  logic              res_valid;
  logic              res_ready;
  logic [CNT_W-1:0]  res_cnt55;
  logic [CNT_W-1:0]  res_cnt59;
  logic [CNT_W-1:0]  res_pkts;
  logic              res_err;
  logic              in_packet;

  modport slave (
    input  in_data, in_valid, det55, det59, beg_p, end_p, res_ready,
    output in_ready, ser_bit, ser_en, res_valid, res_cnt55, res_cnt59,
           res_pkts, res_err, in_packet
  );

  modport master (
    output in_data, in_valid, det55, det59, beg_p, end_p, res_ready,
    input  in_ready, ser_bit, ser_en, res_valid, res_cnt55, res_cnt59,
           res_pkts, res_err, in_packet
  );

endinterface

// File: rtl/detector_stream_ctrl_sat_counter.sv
// Per-word event counter: synchronous clear, increments on inc, holds at
// all-ones and flags saturation.
module sat_counter
  import det_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  assign sat = &cnt;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/detector_stream_ctrl.sv
// Serialises accepted words MSB-first to the detectors, counts detector events
// over each word's window and hands back one result record per word.
module detector_stream_ctrl
  import det_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int DRAIN  = DEF_DRAIN
) (
  input logic clk,
  input logic reset,
  detector_stream_ctrl_if.slave bus
);

  // One down-counter serves both the bit phase and the drain phase.
  localparam int SPAN = (WORD_W > DRAIN) ? WORD_W : DRAIN;
  localparam int BC_W = $clog2(SPAN + 1);

  state_t            state, state_nx;
  logic [WORD_W-1:0] shreg;
  logic [BC_W-1:0]   bit_cnt;
  logic              in_ready_q, ser_en_q, res_valid_q;
  logic              in_packet_q, end_err_q;
  logic              accept, window, last_cnt;
  logic [CNT_W-1:0]  cnt55, cnt59, pkts;
  logic [2:0]        sat;

  assign accept   = in_ready_q && bus.in_valid;
  assign window   = (state == ST_SHIFT) || (state == ST_DRAIN);
  assign last_cnt = (bit_cnt == '0);

  // NOTE: next_state gets its default before the case so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (accept) state_nx = ST_SHIFT;
      ST_SHIFT:  if (last_cnt) state_nx = (DRAIN == 0) ? ST_REPORT : ST_DRAIN;
      ST_DRAIN:  if (last_cnt) state_nx = ST_REPORT;
      ST_REPORT: if (bus.res_ready) state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      in_ready_q  <= 1'b1;
      ser_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state       <= state_nx;
      in_ready_q  <= (state_nx == ST_IDLE);
      ser_en_q    <= (state_nx == ST_SHIFT);
      res_valid_q <= (state_nx == ST_REPORT);
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shreg   <= bus.in_data;
            bit_cnt <= BC_W'(WORD_W - 1);
          end
        end
        ST_SHIFT: begin
          // Zeros shift in, so the MSB (and ser_bit) is 0 once the word is out.
          shreg   <= {shreg[WORD_W-2:0], 1'b0};
          bit_cnt <= last_cnt ? BC_W'(DRAIN - 1) : bit_cnt - 1'b1;
        end
        ST_DRAIN: bit_cnt <= bit_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  // Packet tracking runs every cycle; end_p is applied first so a same-cycle
  // beg_p leaves the packet open.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_packet_q <= 1'b0;
      end_err_q   <= 1'b0;
    end else begin
      if (bus.end_p) in_packet_q <= 1'b0;
      if (bus.beg_p) in_packet_q <= 1'b1;
      if (accept) begin
        end_err_q <= 1'b0;
      end else if (window && bus.end_p && !in_packet_q) begin
        end_err_q <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cnt55 (
    .clk(clk), .reset(reset), .clr(accept),
    .inc(window && bus.det55), .cnt(cnt55), .sat(sat[0])
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt59 (
    .clk(clk), .reset(reset), .clr(accept),
    .inc(window && bus.det59), .cnt(cnt59), .sat(sat[1])
  );

  sat_counter #(.CNT_W(CNT_W)) u_pkts (
    .clk(clk), .reset(reset), .clr(accept),
    .inc(window && bus.end_p && in_packet_q), .cnt(pkts), .sat(sat[2])
  );

  assign bus.in_ready  = in_ready_q;
  assign bus.ser_bit   = shreg[WORD_W-1];
  assign bus.ser_en    = ser_en_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_cnt55 = cnt55;
  assign bus.res_cnt59 = cnt59;
  assign bus.res_pkts  = pkts;
  assign bus.res_err   = end_err_q | (|sat);
  assign bus.in_packet = in_packet_q;

endmodule
